// File: rtl/lwe_decrypt_stream.sv
// Streaming multi-lane LWE decryption: accumulates <a,s> over beats,
// subtracts it from the body word and rounds the phase to a symbol.
module lwe_decrypt_stream #(
   parameter int PLAINTEXT_WIDTH  = 6,
   parameter int CIPHERTEXT_WIDTH = 10,
   parameter int DIMENSION        = 10,
   parameter int LANES            = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   sk_entries,
   input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   ct_entries,
   input  logic                                raw_mode,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [PLAINTEXT_WIDTH-1:0]          result,
   output logic [CIPHERTEXT_WIDTH-1:0]         phase
);

   localparam int CW    = CIPHERTEXT_WIDTH;
   localparam int PW    = PLAINTEXT_WIDTH;
   localparam int BEATS = DIMENSION / LANES;
   localparam int CNT_W = $clog2(BEATS + 1);

   localparam logic [1:0] S_ACCUM = 2'd0;
   localparam logic [1:0] S_BODY  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
   localparam logic [CW-1:0]    HALF = CW'(2 ** (CW - PW - 1));

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    phase_q, phase_d;
   logic [PW-1:0]    result_q, result_d;

   logic [CW-1:0]    lane_sum;
   logic [2*CW-1:0]  prod;
   logic [2*CW-1:0]  sk_x, ct_x;
   logic [CW-1:0]    phase_nxt;
   logic [CW-1:0]    rnd;
   logic [PW-1:0]    res_nxt;
   logic             fire;

   assign in_ready  = (state_q != S_HOLD);
   assign out_valid = (state_q == S_HOLD);
   assign result    = result_q;
   assign phase     = phase_q;
   assign fire      = in_valid & in_ready;

   // Sum of per-lane products, each truncated to CW bits, wrapping mod q
   always_comb begin
      lane_sum = '0;
      prod     = '0;
      sk_x     = '0;
      ct_x     = '0;
      for (int i = 0; i < LANES; i++) begin
         sk_x     = {{CW{1'b0}}, sk_entries[i*CW +: CW]};
         ct_x     = {{CW{1'b0}}, ct_entries[i*CW +: CW]};
         prod     = sk_x * ct_x;
         lane_sum = lane_sum + prod[CW-1:0];
      end
   end

   // Phase of the body beat and its rounded (or raw) plaintext symbol
   always_comb begin
      phase_nxt = ct_entries[CW-1:0] - acc_q;
      rnd       = phase_nxt + HALF;
      res_nxt   = raw_mode ? phase_nxt[PW-1:0] : rnd[CW-1:CW-PW];
   end

   // Next-state logic: clear overrides everything, then the FSM
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      result_d = result_q;
      if (clear) begin
         state_d = S_ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_ACCUM: begin
               if (fire) begin
                  acc_d = acc_q + lane_sum;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST) state_d = S_BODY;
               end
            end
            S_BODY: begin
               if (fire) begin
                  phase_d  = phase_nxt;
                  result_d = res_nxt;
                  state_d  = S_HOLD;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  state_d = S_ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = S_ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_ACCUM;
         acc_q    <= '0;
         cnt_q    <= '0;
         phase_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_lwe_decrypt_stream.sv
// Randomized bench for lwe_decrypt_stream against an arithmetic model
// of LWE decryption (dot product, phase, rounding) at default parameters.
module tb_lwe_decrypt_stream;

   localparam int CW    = 10;
   localparam int PW    = 6;
   localparam int N     = 10;
   localparam int L     = 2;
   localparam int BEATS = N / L;
   localparam int Q     = 1 << CW;
   localparam int P     = 1 << PW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          raw_mode = 1'b0;
   logic          out_ready = 1'b0;
   logic [L*CW-1:0] sk_entries = '0;
   logic [L*CW-1:0] ct_entries = '0;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] result;
   logic [CW-1:0] phase;

   int errs = 0;
   int checks = 0;

   lwe_decrypt_stream #(
      .PLAINTEXT_WIDTH (PW),
      .CIPHERTEXT_WIDTH(CW),
      .DIMENSION       (N),
      .LANES           (L)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sk_entries(sk_entries),
      .ct_entries(ct_entries),
      .raw_mode  (raw_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .phase     (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic partial(input int n);
      for (int k = 0; k < n; k++) begin
         in_valid   = 1'b1;
         sk_entries = L*CW'($urandom);
         ct_entries = L*CW'($urandom);
         tick();
      end
      in_valid = 1'b0;
   endtask

   // mode 0 random, 1 zero key, 2 all ones, 3 all 1023
   task automatic feed(input int mode, input int b, input bit raw,
                       input int hold_n, input bit hold_beat,
                       input bit gaps, input string tag);
      int ska[N];
      int cta[N];
      int acc;
      int ph;
      int res;
      int hp;
      int hr;
      acc = 0;
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: begin ska[i] = $urandom % Q; cta[i] = $urandom % Q; end
            1: begin ska[i] = 0;            cta[i] = $urandom % Q; end
            2: begin ska[i] = 1;            cta[i] = 1;            end
            default: begin ska[i] = Q - 1;  cta[i] = Q - 1;        end
         endcase
         acc = (acc + (ska[i] * cta[i]) % Q) % Q;
      end
      ph  = ((b - acc) % Q + Q) % Q;
      res = raw ? (ph % P) : (((ph + (Q / P) / 2) % Q) / (Q / P));
      for (int k = 0; k < BEATS; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid   = 1'b0;
               sk_entries = L*CW'($urandom);
               ct_entries = L*CW'($urandom);
               tick();
            end
         end
         for (int j = 0; j < L; j++) begin
            sk_entries[j*CW +: CW] = CW'(ska[k*L + j]);
            ct_entries[j*CW +: CW] = CW'(cta[k*L + j]);
         end
         in_valid = 1'b1;
         tick();
      end
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            tick();
         end
      end
      sk_entries         = L*CW'($urandom);
      ct_entries         = L*CW'($urandom);
      ct_entries[CW-1:0] = CW'(b);
      raw_mode           = raw;
      in_valid           = 1'b1;
      tick();
      in_valid = 1'b0;
      raw_mode = 1'($urandom);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_phase"}, 32'(phase), 32'(ph));
      check({tag, "_result"}, 32'(result), 32'(res));
      check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
      hp = ph;
      hr = res;
      for (int h = 0; h < hold_n; h++) begin
         if (hold_beat) begin
            in_valid = 1'b1;
            for (int j = 0; j < L; j++) begin
               sk_entries[j*CW +: CW] = CW'(1);
               ct_entries[j*CW +: CW] = CW'(1);
            end
         end else begin
            in_valid   = 1'($urandom);
            sk_entries = L*CW'($urandom);
            ct_entries = L*CW'($urandom);
         end
         tick();
         check({tag, "_hvalid"}, 32'(out_valid), 32'd1);
         check({tag, "_hphase"}, 32'(phase), 32'(hp));
         check({tag, "_hresult"}, 32'(result), 32'(hr));
         check({tag, "_hinrdy"}, 32'(in_ready), 32'd0);
      end
      if (!hold_beat) in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_done"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_inrdy", 32'(in_ready), 32'd1);
      check("rst_result", 32'(result), 32'd0);
      check("rst_phase", 32'(phase), 32'd0);
      rst_n = 1'b1;
      tick();

      feed(1, 80, 1'b0, 0, 1'b0, 1'b0, "zero80");
      feed(1, 87, 1'b0, 1, 1'b0, 1'b0, "rnd87");
      feed(1, 88, 1'b0, 0, 1'b0, 1'b1, "rnd88");
      feed(1, 1016, 1'b0, 0, 1'b0, 1'b0, "wrap1016");
      feed(2, 58, 1'b0, 0, 1'b0, 1'b0, "ones");
      feed(3, 58, 1'b0, 0, 1'b0, 1'b1, "trunc");
      feed(1, 87, 1'b1, 0, 1'b0, 1'b0, "raw87");

      feed(0, $urandom % Q, 1'b0, 5, 1'b1, 1'b0, "bp");
      feed(2, 58, 1'b0, 0, 1'b0, 1'b0, "after_bp");

      partial(3);
      clear      = 1'b1;
      in_valid   = 1'b1;
      sk_entries = L*CW'($urandom);
      ct_entries = L*CW'($urandom);
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr_valid", 32'(out_valid), 32'd0);
      check("clr_inrdy", 32'(in_ready), 32'd1);
      feed(0, $urandom % Q, 1'b0, 0, 1'b0, 1'b1, "after_clr");

      partial(BEATS);
      clear      = 1'b1;
      in_valid   = 1'b1;
      ct_entries = L*CW'($urandom);
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clrbody_valid", 32'(out_valid), 32'd0);
      feed(2, 500, 1'b0, 0, 1'b0, 1'b0, "after_clrbody");

      partial(3);
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      check("arst_phase", 32'(phase), 32'd0);
      check("arst_inrdy", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      feed(0, $urandom % Q, 1'b0, 0, 1'b0, 1'b0, "after_rst");

      for (int v = 0; v < 20; v++) begin
         feed(0, $urandom % Q, 1'($urandom), $urandom_range(0, 3),
              1'b0, 1'b1, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/lwe_decrypt_stream.md
# lwe_decrypt_stream

Streaming, parametrised LWE decryption engine: it accepts a ciphertext vector `a` with the matching secret-key entries, `LANES` pairs per beat, and then the body word `b`. It computes the phase `b - <a,s> mod q`, rounds it to a plaintext symbol, and presents the result through a valid/ready output holding register. It sits between the ciphertext/key memory readers and the plaintext sink. It replaces the single-lane, row-indexed dot-product accumulator with handshaked, multi-lane, rounding decryption.

## Interface
- `PLAINTEXT_WIDTH`, default 6: plaintext bits; p = 2^PLAINTEXT_WIDTH.
- `CIPHERTEXT_WIDTH`, default 10: ciphertext bits; q = 2^CIPHERTEXT_WIDTH. Must be greater than `PLAINTEXT_WIDTH`.
- `DIMENSION`, default 10: LWE dimension n. Must be a multiple of `LANES`.
- `LANES`, default 2: key/ciphertext pairs consumed per beat. BEATS = DIMENSION/LANES.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort. Drops any partial vector and any pending result.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  engine can accept a beat.
- `sk_entries`  in  LANES*CIPHERTEXT_WIDTH  secret-key entries; lane i is at bits [i*CW +: CW].
- `ct_entries`  in  LANES*CIPHERTEXT_WIDTH  ciphertext entries, same packing. On the body beat, lane 0 carries `b`.
- `raw_mode`  in  1  sampled on the body beat. 1 selects legacy output: the low PLAINTEXT_WIDTH bits of the phase, unrounded.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  sink accepts the result.
- `result`  out  PLAINTEXT_WIDTH  decrypted symbol.
- `phase`  out  CIPHERTEXT_WIDTH  unrounded phase, for debug and noise measurement.

## Operation
- FSM states: ACCUM, BODY, HOLD.
- **ACCUM**
  - `in_ready`=1.
  - Each accepted beat (in_valid & in_ready) adds the sum over lanes of sk_i*ct_i into `acc`, modulo q.
  - `beat_cnt` increments on each accepted beat. The beat that brings the count to BEATS moves the FSM to BODY.
- **BODY**
  - `in_ready`=1.
  - The accepted beat computes `phase_r` = (ct lane0 − acc) mod q and samples raw_mode.
  - `sk_entries` and lanes 1..LANES-1 of `ct_entries` are ignored.
  - Next state is HOLD.
- **HOLD**
  - `in_ready`=0 and `out_valid`=1.
  - `result` and `phase` stay stable until out_ready=1.
  - On out_ready=1: next state is ACCUM, with acc=0 and beat_cnt=0.
- Arithmetic:
  - Products are full 2*CW bits and are truncated to CW bits.
  - The lane sum and the accumulator wrap modulo 2^CW. No saturation.
  - Rounding: result = (phase + 2^(CW−PW−1)) bits [CW−1 : CW−PW]. The carry out of bit CW−1 is dropped, so values near q wrap to 0.
  - raw_mode=1: result = phase[PW−1:0].
- Precedence: rst_n, then clear, then normal operation.
  - clear in any state → ACCUM, acc=0, beat_cnt=0, out_valid=0.
  - A beat presented in the same cycle as clear is discarded.
- in_valid=0 in ACCUM/BODY: the state is held indefinitely. Gaps between beats are legal.

## Timing
- Reset (asynchronous assert, applies immediately):
  - state=ACCUM, acc=0, beat_cnt=0, phase_r=0.
  - Outputs: out_valid=0, result=0, phase=0, in_ready=1.
- Accumulation has no internal latency. acc is updated at the clock edge that accepts the beat.
- Latency: out_valid rises the cycle after the body beat is accepted.
- Minimum occupancy per vector is BEATS+2 cycles: BEATS+1 input beats, plus at least 1 HOLD cycle.
- Handshake rules:
  - in_valid/data must not depend on in_ready.
  - out_valid never drops without out_ready or clear.
- Reset mid-vector discards the partial sum. The next beat after release is treated as beat 0.
- in_ready is a registered function of state only: high in ACCUM and BODY, low in HOLD. There is no combinational path from out_ready.

## Test plan
All scenarios use the defaults, so q/p=16 and the rounding half-step is 8.
- **Zero key:** all sk=0, ct=anything, b=80 → phase=80, result=5. out_valid one cycle after the body beat.
- **Rounding edges:** sk=0, b=87 → result 5; b=88 → result 6; b=1016 → result 0 (wrap).
- **Dot product:** all a=1, s=1, b=58 → acc=10, phase=48, result=3. With a=1023 and s=1023 in every lane, acc=10 mod 1024. This checks product truncation.
- **Backpressure:** hold out_ready=0 for 5 cycles in HOLD with in_valid=1 → in_ready=0 and outputs stable throughout. Release → next vector accepted; the held beat is not lost.
- **Abort/reset:** pulse clear after 3 beats, then feed a full vector → correct result. Repeat with rst_n low for 1 cycle after 3 beats → outputs 0 immediately, next vector correct.
- **Raw mode:** raw_mode=1, sk=0, b=87 → result=23 (87 mod 64), phase=87.
